// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order word fetches to instruction memory and buffers
// returned {pc, instr} pairs for decode, discarding stale responses after a redirect.
module fetch_queue #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pcplus4
);

  localparam int unsigned    PtrW     = $clog2(DEPTH);
  localparam int unsigned    CntW     = $clog2(DEPTH) + 1;
  localparam logic [CntW:0]  DepthVal = (CntW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [31:0]     instr_mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [CntW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CntW:0]   inflight;
  logic            req_fire, rsp_fire, push, pop;

  // Buffered entries plus in-flight fetches never exceed DEPTH, so a push always has room.
  assign inflight       = {1'b0, count_q} + {1'b0, outstanding_q};
  assign imem_req_valid = !reset && !redirect_valid && (inflight < DepthVal);
  assign imem_req_addr  = {fetch_pc_q[XLEN-1:2], 2'b00};

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_fire = imem_rsp_valid && (outstanding_q != '0);
  assign push     = rsp_fire && (drop_cnt_q == '0) && !redirect_valid;

  assign out_valid   = !reset && (count_q != '0);
  assign pop         = out_valid && out_ready && !redirect_valid;
  assign out_pc      = pc_mem_q[rd_ptr_q];
  assign out_instr   = instr_mem_q[rd_ptr_q];
  assign out_pcplus4 = out_pc + XLEN'(4);

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pc_d      = rsp_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;

    if (req_fire) begin
      fetch_pc_d    = fetch_pc_q + XLEN'(4);
      outstanding_d = outstanding_d + CntW'(1);
    end
    if (rsp_fire) begin
      outstanding_d = outstanding_d - CntW'(1);
      if (drop_cnt_q != '0) begin
        drop_cnt_d = drop_cnt_q - CntW'(1);
      end
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
      rsp_pc_d = rsp_pc_q + XLEN'(4);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      // No request issues in a redirect cycle, so this already excludes a response arriving now.
      drop_cnt_d = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pc_q      <= rsp_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && imem_rsp_valid) begin
      assert (outstanding_q != '0)
        else $error("fetch_queue: response received with no fetch outstanding");
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: in-order memory model with configurable latency and a
// scoreboard of expected {pc, instr} entries, tagged by epoch so stale responses are excluded.
module tb_fetch_queue;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus4;

  fetch_queue #(
    .XLEN    (XLEN),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .out_pcplus4   (out_pcplus4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] pc;
    int          epoch;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  mreq_t       memq[$];
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  bit          rsp_en = 1'b1;
  int          epoch = 0;
  int          accepted = 0;
  logic [31:0] exp_fetch = RESET_PC;

  function automatic logic [31:0] instr_of(input logic [31:0] addr);
    return {addr[15:0] ^ 16'h5A5A, addr[31:16] ^ 16'hC3C3};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic drive_rsp();
    if (rsp_en && memq.size() > 0 && memq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(memq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  endtask

  // Evaluates what the coming rising edge will do and updates the model accordingly.
  task automatic observe();
    exp_t  e;
    mreq_t m;
    if (reset) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_req_valid", imem_req_valid, 0);
      memq.delete();
      sb.delete();
      exp_fetch = RESET_PC;
      epoch++;
      return;
    end
    check("out_valid", out_valid, sb.size() != 0);
    if (redirect_valid) check("redir_no_req", imem_req_valid, 0);
    if (out_valid && out_ready && !redirect_valid && sb.size() != 0) begin
      e = sb.pop_front();
      check("out_pc", out_pc, e.pc);
      check("out_instr", out_instr, e.instr);
      check("out_pcplus4", out_pcplus4, e.pc + 32'd4);
    end
    if (imem_rsp_valid) begin
      m = memq.pop_front();
      if (!redirect_valid && m.epoch == epoch) sb.push_back('{m.pc, instr_of(m.pc)});
    end
    if (imem_req_valid && imem_req_ready) begin
      check("req_addr", imem_req_addr, exp_fetch);
      memq.push_back('{imem_req_addr, exp_fetch, epoch, cyc + lat});
      exp_fetch = exp_fetch + 32'd4;
      accepted++;
    end
    if (redirect_valid) begin
      epoch++;
      sb.delete();
      exp_fetch = {redirect_pc[31:2], 2'b00};
    end
  endtask

  task automatic cycle();
    drive_rsp();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
  endtask

  task automatic wait_out_valid(input string tag);
    for (int i = 0; i < 40 && !out_valid; i++) cycle();
    check(tag, out_valid, 1);
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    @(posedge clk);
    #1;

    // Reset state and first request right after release
    repeat (2) cycle();
    reset = 1'b0;
    #1;
    check("first_req_valid", imem_req_valid, 1);
    check("first_req_addr", imem_req_addr, RESET_PC);

    // Streaming with 1-cycle memory: one entry per cycle once filled
    repeat (4) cycle();
    for (int i = 0; i < 8; i++) begin
      check("stream_valid", out_valid, 1);
      cycle();
    end

    // Decode stalled: exactly DEPTH fetches, then requests stop
    do_reset();
    out_ready = 1'b0;
    accepted  = 0;
    repeat (10) cycle();
    check("hold_accepted", accepted, DEPTH);
    check("hold_req_valid", imem_req_valid, 0);
    check("hold_out_valid", out_valid, 1);
    out_ready = 1'b1;
    repeat (4) cycle();
    check("resume_fetch", accepted > DEPTH, 1);
    repeat (4) cycle();

    // Redirect with three fetches in flight and no response that cycle
    do_reset();
    lat = 3;
    repeat (3) cycle();
    rsp_en         = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    cycle();
    redirect_valid = 1'b0;
    rsp_en         = 1'b1;
    wait_out_valid("redir_wait");
    check("redir_head_pc", out_pc, 32'h0000_0100);
    check("redir_head_instr", out_instr, instr_of(32'h0000_0100));
    check("redir_head_pcplus4", out_pcplus4, 32'h0000_0104);
    out_ready = 1'b1;
    repeat (8) cycle();

    // Redirect coinciding with a response and a pop
    do_reset();
    lat = 2;
    repeat (8) cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    drive_rsp();
    #1;
    check("pre_redir_rsp", imem_rsp_valid, 1);
    check("pre_redir_out", out_valid, 1);
    cycle();
    redirect_valid = 1'b0;
    #1;
    check("post_redir_empty", out_valid, 0);
    repeat (10) cycle();

    // Fetch address wraps past the top of the address space
    do_reset();
    lat            = 1;
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    wait_out_valid("wrap_wait");
    check("wrap_head_pc", out_pc, 32'hFFFF_FFFC);
    check("wrap_head_pcplus4", out_pcplus4, 32'h0000_0000);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    wait_out_valid("wrap_wait2");
    check("wrap_next_pc", out_pc, 32'h0000_0000);
    check("wrap_next_pcplus4", out_pcplus4, 32'h0000_0004);

    // Reset with two entries buffered and two fetches outstanding
    do_reset();
    rsp_en = 1'b0;
    repeat (5) cycle();
    rsp_en = 1'b1;
    repeat (2) cycle();
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_req_valid", imem_req_valid, 0);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    #1;
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_req_valid", imem_req_valid, 1);
    check("post_rst_req_addr", imem_req_addr, RESET_PC);
    out_ready = 1'b1;
    repeat (8) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
